// File: rtl/clk_divider.sv
// Integer clock divider with 50% duty cycle for even and odd ratios.
// Odd ratios stretch the high phase by half a cycle using a falling-edge flop.
module clk_divider #(
   parameter int unsigned DIVISOR = 15
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_clk
);

   localparam int unsigned WIDTH = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

   generate
      if (DIVISOR < 1) begin : g_bad
         $error("clk_divider: DIVISOR must be >= 1");
         assign o_clk = 1'b0;
      end else if (DIVISOR == 1) begin : g_pass
         assign o_clk = i_clk & ~i_rst;
      end else begin : g_div
         localparam logic [WIDTH-1:0] LAST = WIDTH'(DIVISOR - 1);
         localparam logic [WIDTH-1:0] HIGH =
            WIDTH'((DIVISOR % 2 == 0) ? DIVISOR / 2 : (DIVISOR - 1) / 2);

         logic [WIDTH-1:0] cnt_q;
         logic [WIDTH-1:0] cnt_d;
         logic             a_q;
         logic             a_d;

         always_comb begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            a_d   = (cnt_d < HIGH);
         end

         // Reset parks the counter on LAST so the first edge starts a high phase
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               cnt_q <= LAST;
               a_q   <= 1'b0;
            end else begin
               cnt_q <= cnt_d;
               a_q   <= a_d;
            end
         end

         if (DIVISOR % 2 == 0) begin : g_even
            assign o_clk = a_q;
         end else begin : g_odd
            logic b_q;

            always_ff @(negedge i_clk or posedge i_rst) begin
               if (i_rst) begin
                  b_q <= 1'b0;
               end else begin
                  b_q <= a_q;
               end
            end

            assign o_clk = a_q | b_q;
         end
      end
   endgenerate

endmodule

// File: tb/tb_clk_divider.sv
// Scoreboard bench for clk_divider at N = 15, 4, 1, 2, 3.
// Expected level: high for the first N half-periods of every 2N after release.
`timescale 1ns/100ps
module tb_clk_divider;

   localparam int NDUT = 5;
   localparam int NS [NDUT] = '{15, 4, 1, 2, 3};

   typedef struct {
      logic [NDUT-1:0] exp;
      int              h;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            o15;
   logic            o4;
   logic            o1;
   logic            o2;
   logic            o3;
   logic [NDUT-1:0] act;

   exp_t q[$];
   event sample_ev;
   int   vectors = 0;
   int   miscompares = 0;
   int   h = -1;

   always #1 clk = ~clk;

   clk_divider #(.DIVISOR(15)) u_d15 (.i_clk(clk), .i_rst(rst), .o_clk(o15));
   clk_divider #(.DIVISOR(4))  u_d4  (.i_clk(clk), .i_rst(rst), .o_clk(o4));
   clk_divider #(.DIVISOR(1))  u_d1  (.i_clk(clk), .i_rst(rst), .o_clk(o1));
   clk_divider #(.DIVISOR(2))  u_d2  (.i_clk(clk), .i_rst(rst), .o_clk(o2));
   clk_divider #(.DIVISOR(3))  u_d3  (.i_clk(clk), .i_rst(rst), .o_clk(o3));

   assign act = {o3, o2, o1, o4, o15};

   function automatic logic [NDUT-1:0] expect_v(input int hh, input logic r);
      logic [NDUT-1:0] e;
      e = '0;
      if (!r && hh >= 0) begin
         for (int i = 0; i < NDUT; i++) begin
            e[i] = ((hh % (2 * NS[i])) < NS[i]);
         end
      end
      return e;
   endfunction

   task automatic push_and_sample();
      exp_t e;
      e.exp = expect_v(h, rst);
      e.h   = h;
      q.push_back(e);
      #0.1;
      -> sample_ev;
   endtask

   // One half-period of clk; h counts edges since the first post-release posedge
   task automatic slot();
      @(clk);
      if (rst) h = -1;
      else if (h >= 0) h++;
      else if (clk) h = 0;
      #0.1;
      push_and_sample();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(sample_ev);
         if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_empty t=%0t", $time);
         end else begin
            e = q.pop_front();
            for (int i = 0; i < NDUT; i++) begin
               vectors++;
               if (act[i] !== e.exp[i]) begin
                  miscompares++;
                  $display("FAIL o_clk N=%0d h=%0d t=%0t: got %b, expected %b",
                           NS[i], e.h, $time, act[i], e.exp[i]);
               end
            end
         end
      end
   end

   initial begin : stim
      #0.3 rst = 1'b1;
      #0.1 push_and_sample();
      repeat (8) slot();
      @(negedge clk);
      #0.2 rst = 1'b0;
      repeat (120) slot();
      for (int k = 0; k < 60 && (h % 30) != 5; k++) slot();
      // Assert reset between edges while the N=15 output is high
      #0.3 rst = 1'b1;
      #0.1 push_and_sample();
      repeat (4) slot();
      @(negedge clk);
      #0.2 rst = 1'b0;
      repeat (70) slot();
      #0.5;
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
